// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BUS_W       = 64;

  typedef enum logic [0:0] {
    StReq,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; reads zero when empty.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_data,
  output logic                       o_valid,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CntW'(Depth)) || w_do_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge i_clock) begin
    if (w_do_push && !i_reset && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-memory initiator: one fixed-latency access at a time, results
// buffered with their PC and handed to decode over valid/ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_address,
  input  logic [BUS_W-1:0]   mem_data,
  output logic               mem_chip_select,
  output logic               mem_output_enable,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      r_state, w_state_d;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [3:0]        r_wait_cnt, w_wait_cnt_d;
  logic              r_hold, w_hold_d;

  logic              w_issue;
  logic              w_capture;
  logic              w_bus_active;
  logic [CntW-1:0]   w_fifo_count;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;
  logic              w_unused;

  // r_hold forces one idle bus cycle after a redirect before the new fetch.
  assign w_issue = (r_state == StReq) && !r_hold && !reset && !redirect &&
                   (32'(w_fifo_count) < FIFO_DEPTH);
  assign w_capture    = (r_state == StWait) && (r_wait_cnt == 4'd1);
  assign w_bus_active = w_issue || ((r_state == StWait) && !reset);

  assign mem_chip_select   = w_bus_active;
  assign mem_output_enable = w_bus_active;
  assign mem_address       = w_issue ? r_fetch_pc : r_addr;

  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    w_addr_d     = r_addr;
    w_wait_cnt_d = r_wait_cnt;
    w_hold_d     = 1'b0;
    unique case (r_state)
      StReq: begin
        if (w_issue) begin
          w_state_d    = StWait;
          w_addr_d     = r_fetch_pc;
          w_wait_cnt_d = 4'(WAIT_CYCLES);
        end
      end
      StWait: begin
        w_wait_cnt_d = r_wait_cnt - 4'd1;
        if (w_capture) begin
          w_state_d    = StReq;
          w_fetch_pc_d = next_pc(r_fetch_pc);
        end
      end
      default: w_state_d = StReq;
    endcase
    if (redirect) begin
      w_state_d    = StReq;
      w_fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      w_hold_d     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StReq;
      r_fetch_pc <= RESET_PC;
      r_addr     <= '0;
      r_wait_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_addr     <= w_addr_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_hold     <= w_hold_d;
    end
  end

  assign w_push_entry.pc    = r_fetch_pc;
  assign w_push_entry.instr = mem_data[INSTR_W-1:0];

  fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width($bits(fetch_entry_t))
  ) u_fifo (
    .i_clock(clock),
    .i_reset(reset),
    .i_flush(redirect),
    .i_push (w_capture && !redirect),
    .i_data (w_push_entry),
    .i_pop  (instr_valid && instr_ready),
    .o_data (w_head),
    .o_valid(instr_valid),
    .o_count(w_fifo_count)
  );

  assign instr    = w_head.instr;
  assign instr_pc = w_head.pc;

  assign w_unused = ^{mem_data[BUS_W-1:INSTR_W], redirect_pc[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a stream-level model checks one instance every
// cycle; directed literal checks pin timing, wrap-around and mid-access reset.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH_A = 2;
  localparam int unsigned WAIT_A  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h9100_2BE0;
      32'h0000_001C: return 32'h17FF_FFF8;
      default:       return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Instance A: defaults, checked by the model.
  logic        rst_a = 1'b1, rdy_a = 1'b1, redir_a = 1'b0;
  logic [31:0] rpc_a = '0, addr_a, instr_a, pc_a;
  logic        cs_a, oe_a, valid_a;
  logic [63:0] mdata_a;
  assign mdata_a = {32'hCAFE_F00D, (cs_a && oe_a) ? rom(addr_a) : 32'hDEAD_BEEF};

  instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(WAIT_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
    .clock(clk), .reset(rst_a), .mem_address(addr_a), .mem_data(mdata_a),
    .mem_chip_select(cs_a), .mem_output_enable(oe_a), .instr(instr_a), .instr_pc(pc_a),
    .instr_valid(valid_a), .instr_ready(rdy_a), .redirect(redir_a), .redirect_pc(rpc_a)
  );

  // Instance B: PC wrap-around.
  logic        rst_b = 1'b1;
  logic [31:0] addr_b, instr_b, pc_b;
  logic        cs_b, oe_b, valid_b;
  logic [63:0] mdata_b;
  assign mdata_b = {32'h0, rom(addr_b)};

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .WAIT_CYCLES(1), .FIFO_DEPTH(2)) dut_b (
    .clock(clk), .reset(rst_b), .mem_address(addr_b), .mem_data(mdata_b),
    .mem_chip_select(cs_b), .mem_output_enable(oe_b), .instr(instr_b), .instr_pc(pc_b),
    .instr_valid(valid_b), .instr_ready(1'b1), .redirect(1'b0), .redirect_pc(32'h0)
  );

  // Instance C: longer access time, reset mid-access.
  logic        rst_c = 1'b1;
  logic [31:0] addr_c, instr_c, pc_c;
  logic        cs_c, oe_c, valid_c;
  logic [63:0] mdata_c;
  assign mdata_c = {32'h1234_5678, rom(addr_c)};

  instr_fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(3), .FIFO_DEPTH(2)) dut_c (
    .clock(clk), .reset(rst_c), .mem_address(addr_c), .mem_data(mdata_c),
    .mem_chip_select(cs_c), .mem_output_enable(oe_c), .instr(instr_c), .instr_pc(pc_c),
    .instr_valid(valid_c), .instr_ready(1'b0), .redirect(1'b0), .redirect_pc(32'h0)
  );

  // Stream model for A: every completed access of WAIT_A+1 bus cycles delivers
  // {addr, rom(addr)} in order; redirect discards everything not yet delivered.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  int          acc_len = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] cur_addr = 32'h0;
  bit          dead = 1'b0;
  bit          prev_rst = 1'b0;

  always @(negedge clk) begin
    if (rst_a) begin
      if (prev_rst) begin
        chk("m_rst_cs", cs_a, 0);
        chk("m_rst_oe", oe_a, 0);
        chk("m_rst_addr", addr_a, 0);
        chk("m_rst_valid", valid_a, 0);
        chk("m_rst_instr", instr_a, 0);
        chk("m_rst_pc", pc_a, 0);
      end
      q.delete();
      acc_len  = 0;
      exp_pc   = 32'h0;
      dead     = 1'b0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      chk("m_cs_eq_oe", cs_a, oe_a);
      chk("m_valid", valid_a, 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("m_head_pc", pc_a, q[0].pc);
        chk("m_head_instr", instr_a, q[0].ins);
      end else begin
        chk("m_empty_instr", instr_a, 0);
        chk("m_empty_pc", pc_a, 0);
      end
      if (dead) chk("m_post_redirect_cs", cs_a, 0);
      if (cs_a) begin
        if (acc_len == 0) begin
          chk("m_issue_addr", addr_a, exp_pc);
          chk("m_issue_room", 32'(q.size() < DEPTH_A), 1);
          cur_addr = addr_a;
        end else begin
          chk("m_hold_addr", addr_a, cur_addr);
        end
        acc_len++;
      end else if (acc_len != 0) begin
        chk("m_access_cut_short", 32'(acc_len), 0);
      end else if (!dead && !redir_a && q.size() < DEPTH_A) begin
        chk("m_missed_issue", cs_a, 1);
      end
      if (valid_a && rdy_a) void'(q.pop_front());
      if (redir_a) begin
        q.delete();
        acc_len = 0;
        exp_pc  = {rpc_a[31:2], 2'b00};
        dead    = 1'b1;
      end else begin
        dead = 1'b0;
        if (acc_len == WAIT_A + 1) begin
          q.push_back('{cur_addr, rom(cur_addr)});
          exp_pc  = cur_addr + 32'd4;
          acc_len = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;

    // A: streaming from reset, then redirect mid-access to an unaligned target.
    rst_a = 1'b0; cyc = 0;
    @(negedge clk); chk("a_c0_cs", cs_a, 1); chk("a_c0_addr", addr_a, 32'h0);
    go(1); @(negedge clk); chk("a_c1_valid", valid_a, 0);
    go(2); @(negedge clk);
    chk("a_c2_valid", valid_a, 1); chk("a_c2_instr", instr_a, 32'h9100_2BE0);
    chk("a_c2_pc", pc_a, 32'h0); chk("a_c2_addr", addr_a, 32'h4);
    go(4); @(negedge clk); chk("a_c4_pc", pc_a, 32'h4); chk("a_c4_addr", addr_a, 32'h8);
    go(9); redir_a = 1'b1; rpc_a = 32'h1E; @(negedge clk);
    go(10); redir_a = 1'b0; @(negedge clk);
    chk("a_rd1_valid", valid_a, 0); chk("a_rd1_cs", cs_a, 0);
    go(11); @(negedge clk); chk("a_rd2_cs", cs_a, 1); chk("a_rd2_addr", addr_a, 32'h1C);
    go(13); @(negedge clk);
    chk("a_rd_valid", valid_a, 1); chk("a_rd_pc", pc_a, 32'h1C);
    chk("a_rd_instr", instr_a, 32'h17FF_FFF8);

    // A: redirect coinciding with the capture of pc 0x14.
    go(16); rst_a = 1'b1; go(18); rst_a = 1'b0; cyc = 0;
    go(11); redir_a = 1'b1; rpc_a = 32'h40; @(negedge clk);
    go(12); redir_a = 1'b0; @(negedge clk);
    chk("a_cap_valid", valid_a, 0); chk("a_cap_cs", cs_a, 0);
    go(13); @(negedge clk); chk("a_cap_addr", addr_a, 32'h40);
    go(15); @(negedge clk); chk("a_cap_valid2", valid_a, 1); chk("a_cap_pc", pc_a, 32'h40);

    // A: back-pressure fills the buffer, then drains in order.
    go(17); rst_a = 1'b1; rdy_a = 1'b0; go(19); rst_a = 1'b0; cyc = 0;
    go(4); @(negedge clk);
    chk("a_bp_cs", cs_a, 0); chk("a_bp_addr", addr_a, 32'h4); chk("a_bp_pc", pc_a, 32'h0);
    go(5); @(negedge clk); chk("a_bp_cs2", cs_a, 0); chk("a_bp_pc2", pc_a, 32'h0);
    go(6); rdy_a = 1'b1; @(negedge clk); chk("a_dr_pc0", pc_a, 32'h0);
    go(7); @(negedge clk);
    chk("a_dr_pc1", pc_a, 32'h4); chk("a_dr_cs", cs_a, 1); chk("a_dr_addr", addr_a, 32'h8);
    go(9); @(negedge clk); chk("a_dr_pc2", pc_a, 32'h8);
    go(11); rst_a = 1'b1;

    // B: address wrap-around.
    go(13); rst_b = 1'b0; cyc = 0;
    @(negedge clk); chk("b_c0_addr", addr_b, 32'hFFFF_FFF8); chk("b_c0_cs", cs_b, 1);
    go(2); @(negedge clk); chk("b_c2_addr", addr_b, 32'hFFFF_FFFC);
    chk("b_c2_pc", pc_b, 32'hFFFF_FFF8);
    go(4); @(negedge clk); chk("b_c4_addr", addr_b, 32'h0); chk("b_c4_pc", pc_b, 32'hFFFF_FFFC);
    go(6); @(negedge clk); chk("b_c6_pc", pc_b, 32'h0); chk("b_c6_instr", instr_b, 32'h9100_2BE0);
    go(7); rst_b = 1'b1;

    // C: reset asserted during the wait phase of the second access.
    go(9); rst_c = 1'b0; cyc = 0;
    go(3); @(negedge clk); chk("c_c3_cs", cs_c, 1); chk("c_c3_valid", valid_c, 0);
    go(4); @(negedge clk); chk("c_c4_pc", pc_c, 32'h0); chk("c_c4_addr", addr_c, 32'h4);
    go(5); rst_c = 1'b1;
    go(6); @(negedge clk);
    chk("c_rst_addr", addr_c, 0); chk("c_rst_cs", cs_c, 0); chk("c_rst_oe", oe_c, 0);
    chk("c_rst_instr", instr_c, 0); chk("c_rst_pc", pc_c, 0); chk("c_rst_valid", valid_c, 0);
    go(7); rst_c = 1'b0; cyc = 0;
    @(negedge clk); chk("c_re_cs", cs_c, 1); chk("c_re_addr", addr_c, 32'h0);
    go(3); @(negedge clk); chk("c_re_stale", valid_c, 0);
    go(4); @(negedge clk);
    chk("c_re_valid", valid_c, 1); chk("c_re_pc", pc_c, 32'h0);
    chk("c_re_instr", instr_c, 32'h9100_2BE0);

    go(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
